// File: rtl/ray_grid_walker_pkg.sv
// Shared types and constants for the ray grid walker.
package ray_grid_walker_pkg;

  localparam int GRID_BITS  = 6;   // bits per cell coordinate (64 cells per axis)
  localparam int WORLD_BITS = 12;  // integer world-unit bits per axis
  localparam int CELL_SHIFT = 6;   // 64 world units per cell

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  // Map address layout: {cellY, cellX}.
  function automatic logic [2*GRID_BITS-1:0] pack_addr(
    input logic [GRID_BITS-1:0] cell_y,
    input logic [GRID_BITS-1:0] cell_x
  );
    return {cell_y, cell_x};
  endfunction

endpackage

// File: rtl/ray_grid_walker_axis_stepper.sv
// One axis of the marcher: proposes the next position, flags leaving the
// world, and reports whether the cell index would change.
module axis_stepper
  import ray_grid_walker_pkg::*;
#(
  parameter int FRAC_BITS = 4
) (
  input  logic [WORLD_BITS+FRAC_BITS-1:0] pos,
  input  logic [7:0]                      step,
  output logic [WORLD_BITS+FRAC_BITS-1:0] next_pos,
  output logic                            out_of_range,
  output logic                            cell_changed
);

  localparam int PW = WORLD_BITS + FRAC_BITS;

  logic [PW:0] sum;

  // One extra bit: every sum outside [0, 2^PW-1] (underflow or overflow)
  // lands with the top bit set, so the position can never wrap.
  always_comb begin
    sum          = {1'b0, pos} + {{(PW + 1 - 8){step[7]}}, step};
    next_pos     = sum[PW-1:0];
    out_of_range = sum[PW];
    cell_changed = (sum[PW-1 -: GRID_BITS] != pos[PW-1 -: GRID_BITS]);
  end

endmodule

// File: rtl/ray_grid_walker.sv
// Fixed-step ray marcher over a 64x64-cell map; probes one cell per clock
// and reports the first wall, a step-limit miss, or leaving the world.
module ray_grid_walker
  import ray_grid_walker_pkg::*;
#(
  parameter int MAX_STEPS = 255,
  parameter int FRAC_BITS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] start_x,
  input  logic [11:0] start_y,
  input  logic [7:0]  step_x,
  input  logic [7:0]  step_y,
  output logic [11:0] grid_address,
  input  logic        grid_out,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic        hit_side,
  output logic [11:0] hit_cell,
  output logic [7:0]  step_count
);

  localparam int PW = WORLD_BITS + FRAC_BITS;

  state_t state, state_next;

  logic [PW-1:0] pos_x, pos_y;
  logic [PW-1:0] next_x, next_y;
  logic [7:0]    step_x_q, step_y_q;
  logic [7:0]    count;
  logic          side;
  logic          oor_x, oor_y, chg_x, chg_y;

  logic          load, advance, finish, finish_hit;
  logic [11:0]   probe_addr;

  axis_stepper #(.FRAC_BITS(FRAC_BITS)) u_step_x (
    .pos          (pos_x),
    .step         (step_x_q),
    .next_pos     (next_x),
    .out_of_range (oor_x),
    .cell_changed (chg_x)
  );

  axis_stepper #(.FRAC_BITS(FRAC_BITS)) u_step_y (
    .pos          (pos_y),
    .step         (step_y_q),
    .next_pos     (next_y),
    .out_of_range (oor_y),
    .cell_changed (chg_y)
  );

  assign probe_addr = pack_addr(GRID_BITS'(pos_y >> (CELL_SHIFT + FRAC_BITS)),
                                GRID_BITS'(pos_x >> (CELL_SHIFT + FRAC_BITS)));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and per-cycle walk decision (wall, step limit, exit, advance).
  always_comb begin
    state_next   = state;
    load         = 1'b0;
    advance      = 1'b0;
    finish       = 1'b0;
    finish_hit   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    grid_address = 12'h000;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = WALK;
        end
      end
      WALK: begin
        busy         = 1'b1;
        grid_address = probe_addr;
        if (grid_out) begin
          finish     = 1'b1;
          finish_hit = 1'b1;
        end else if (count == 8'(MAX_STEPS)) begin
          finish = 1'b1;
        end else if (oor_x || oor_y) begin
          finish = 1'b1;
        end else begin
          advance = 1'b1;
        end
        if (finish) state_next = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        grid_address = probe_addr;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Walk datapath: position, step, advance count and last-changed-axis flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_x    <= '0;
      pos_y    <= '0;
      step_x_q <= '0;
      step_y_q <= '0;
      count    <= '0;
      side     <= 1'b0;
    end else if (load) begin
      pos_x    <= {start_x, FRAC_BITS'(0)};
      pos_y    <= {start_y, FRAC_BITS'(0)};
      step_x_q <= step_x;
      step_y_q <= step_y;
      count    <= '0;
      side     <= 1'b0;
    end else if (advance) begin
      pos_x <= next_x;
      pos_y <= next_y;
      count <= count + 8'd1;
      if (chg_x)      side <= 1'b0;
      else if (chg_y) side <= 1'b1;
    end
  end

  // Result registers, updated only when a walk finishes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit        <= 1'b0;
      hit_side   <= 1'b0;
      hit_cell   <= '0;
      step_count <= '0;
    end else if (finish) begin
      hit        <= finish_hit;
      hit_side   <= side;
      hit_cell   <= probe_addr;
      step_count <= count;
    end
  end

endmodule

// File: tb/tb_ray_grid_walker.sv
// Directed bench for ray_grid_walker: table of rays with hand-computed
// results, plus a start-while-busy / reset-abort sequence.
module tb_ray_grid_walker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] start_x = '0, start_y = '0;
  logic [7:0]  step_x = '0, step_y = '0;
  logic [11:0] grid_address;
  logic        grid_out;
  logic        busy, done, hit, hit_side;
  logic [11:0] hit_cell;
  logic [7:0]  step_count;

  int errors = 0;
  int checks = 0;

  ray_grid_walker dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .start_x      (start_x),
    .start_y      (start_y),
    .step_x       (step_x),
    .step_y       (step_y),
    .grid_address (grid_address),
    .grid_out     (grid_out),
    .busy         (busy),
    .done         (done),
    .hit          (hit),
    .hit_side     (hit_side),
    .hit_cell     (hit_cell),
    .step_count   (step_count)
  );

  always #5 clock = ~clock;

  // Level map: walls in columns x=0 and x=2 for rows y=0..4.
  logic [5:0] map_x, map_y;
  assign map_x    = grid_address[5:0];
  assign map_y    = grid_address[11:6];
  assign grid_out = ((map_x == 6'd0) || (map_x == 6'd2)) && (map_y <= 6'd4);

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Launch one ray (start sampled at edge 0) and wait for done.
  // lat is the cycle number in which done was seen, cycle 1 following edge 0.
  task automatic run_ray(input logic [11:0] sx, input logic [11:0] sy,
                         input logic [7:0] dx, input logic [7:0] dy,
                         output int lat, output bit got);
    int cyc;
    @(negedge clock);
    start_x = sx; start_y = sy; step_x = dx; step_y = dy; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 1;
    got = 1'b0;
    lat = -1;
    while (!got && cyc < 400) begin
      if (done) begin
        got = 1'b1;
        lat = cyc;
      end else begin
        @(posedge clock);
        #1 cyc++;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [11:0] sx, sy;
    logic [7:0]  dx, dy;
    logic        e_hit, e_side;
    logic [11:0] e_cell;
    int          e_count;
    int          e_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int  lat;
    bit  got;
    int  done_seen;

    // Step 16 = 1.0 world unit in Q3.4; 0xF0 = -1.0.
    vecs[0] = '{"s1_east",   12'd96, 12'd100, 8'd16,  8'd0,   1'b1, 1'b0, 12'h042, 32,  34};
    vecs[1] = '{"s2_west",   12'd96, 12'd100, 8'hF0,  8'd0,   1'b1, 1'b0, 12'h040, 33,  35};
    vecs[2] = '{"s3_limit",  12'd96, 12'd100, 8'd0,   8'd16,  1'b0, 1'b1, 12'h141, 255, 257};
    vecs[3] = '{"s4_exit",   12'd96, 12'd10,  8'd0,   8'hF0,  1'b0, 1'b0, 12'h001, 10,  12};
    vecs[4] = '{"s5_origin", 12'd10, 12'd10,  8'd5,   8'd7,   1'b1, 1'b0, 12'h000, 0,   2};

    repeat (3) @(posedge clock);
    #1;
    check("rst_busy",   busy,         0);
    check("rst_done",   done,         0);
    check("rst_hit",    hit,          0);
    check("rst_cell",   hit_cell,     0);
    check("rst_count",  step_count,   0);
    check("rst_addr",   grid_address, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_ray(vecs[i].sx, vecs[i].sy, vecs[i].dx, vecs[i].dy, lat, got);
      check({vecs[i].name, "_got_done"}, got, 1);
      check({vecs[i].name, "_latency"},  lat, vecs[i].e_lat);
      check({vecs[i].name, "_hit"},      hit, vecs[i].e_hit);
      check({vecs[i].name, "_side"},     hit_side, vecs[i].e_side);
      check({vecs[i].name, "_cell"},     hit_cell, vecs[i].e_cell);
      check({vecs[i].name, "_count"},    step_count, vecs[i].e_count);
      @(posedge clock);
      #1;
      check({vecs[i].name, "_done_pulse"}, done, 0);
      check({vecs[i].name, "_idle_addr"},  grid_address, 0);
      check({vecs[i].name, "_hold_cell"},  hit_cell, vecs[i].e_cell);
    end

    // Start while busy, then reset mid-walk.
    @(negedge clock);
    start_x = 12'd96; start_y = 12'd100; step_x = 8'd16; step_y = 8'd0; start = 1'b1;
    @(posedge clock);                 // edge 0
    #1 start = 1'b0;                  // cycle 1
    repeat (4) @(posedge clock);
    #1;                               // cycle 5
    start_x = 12'd2000; start_y = 12'd2000; step_x = 8'd0; step_y = 8'd0; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;                  // cycle 6
    repeat (2) @(posedge clock);
    #1;                               // cycle 8
    check("s6_busy_c8", busy, 1);
    check("s6_addr_c8", grid_address, 12'h041);
    repeat (2) @(posedge clock);
    #1;                               // cycle 10
    reset = 1'b1;
    #1;
    check("s6_rst_busy",  busy,         0);
    check("s6_rst_done",  done,         0);
    check("s6_rst_hit",   hit,          0);
    check("s6_rst_cell",  hit_cell,     0);
    check("s6_rst_count", step_count,   0);
    check("s6_rst_addr",  grid_address, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done || busy) done_seen++;
    end
    check("s6_no_done_after_rst", done_seen, 0);

    run_ray(12'd96, 12'd100, 8'd16, 8'd0, lat, got);
    check("s6_rerun_got_done", got, 1);
    check("s6_rerun_latency",  lat, 34);
    check("s6_rerun_hit",      hit, 1);
    check("s6_rerun_cell",     hit_cell, 12'h042);
    check("s6_rerun_count",    step_count, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
